snake_body_ctrl: RTL

Snake movement/body controller, directly downstream of the speed divider: consumes its one-cycle `move_en` tick and advances the snake one grid cell per tick. Owns the heading (filtered from key pulses), the segment coordinate store, growth, and wall/self collision → game-over. Renderer reads segments through a combinational read port; game logic drives `start`/`grow`.

---
 rtl/snake_body_ctrl_pkg.sv | 31 +++
 rtl/snake_body_ctrl_if.sv | 38 +++
 rtl/snake_body_ctrl_dir_filter.sv | 43 ++++
 rtl/snake_body_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/snake_body_ctrl_pkg.sv
// Shared encodings for the snake movement/body controller: headings, FSM states
// and the default grid geometry.
package snake_pkg;

    localparam int GRID_W_DEF  = 40;
    localparam int GRID_H_DEF  = 30;
    localparam int XW_DEF      = 6;
    localparam int YW_DEF      = 5;
    localparam int MAX_LEN_DEF = 16;
    localparam int START_X_DEF = 20;
    localparam int START_Y_DEF = 15;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_e;

    // Opposite headings differ only in bit 1.
    function automatic dir_e reverse_dir(input dir_e d);
        return dir_e'(d ^ 2'd2);
    endfunction

endpackage

// File: rtl/snake_body_ctrl_if.sv
// Control/readout bundle between game logic, renderer and the snake controller.
// master = game logic / renderer side, slave = snake_body_ctrl.
interface snake_body_ctrl_if #(
    parameter int XW      = snake_pkg::XW_DEF,
    parameter int YW      = snake_pkg::YW_DEF,
    parameter int MAX_LEN = snake_pkg::MAX_LEN_DEF
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = IW + 1;

    logic          move_en;
    logic          start;
    logic [3:0]    key_dir;
    logic          grow;
    logic [IW-1:0] rd_idx;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          rd_valid;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [LW-1:0] snake_len;
    logic          running;
    logic          game_over;
    logic          step_done;

    modport master (
        output move_en, start, key_dir, grow, rd_idx,
        input  rd_x, rd_y, rd_valid, head_x, head_y, snake_len,
               running, game_over, step_done
    );

    modport slave (
        input  move_en, start, key_dir, grow, rd_idx,
        output rd_x, rd_y, rd_valid, head_x, head_y, snake_len,
               running, game_over, step_done
    );

endinterface

// File: rtl/snake_body_ctrl_dir_filter.sv
// Heading request filter: picks one key by priority, drops reversals and holds
// the pending heading that the next step will commit.
module snake_dir_filter
    import snake_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init_i,
    input  logic       run_i,
    input  logic       step_i,
    input  logic [3:0] key_dir_i,
    input  dir_e       dir_i,
    output dir_e       pend_dir_o
);

    dir_e pend_dir_q, pend_dir_d;
    dir_e req_dir, ref_dir;
    logic req_valid;

    // On a step edge the pending heading becomes the committed one, so a key
    // arriving in that same cycle is judged against it.
    always_comb begin
        req_valid  = |key_dir_i;
        req_dir    = DIR_LEFT;
        if (key_dir_i[0])      req_dir = DIR_UP;
        else if (key_dir_i[1]) req_dir = DIR_RIGHT;
        else if (key_dir_i[2]) req_dir = DIR_DOWN;
        ref_dir    = step_i ? pend_dir_q : dir_i;
        pend_dir_d = pend_dir_q;
        if (init_i)
            pend_dir_d = DIR_RIGHT;
        else if (run_i && req_valid && (req_dir != reverse_dir(ref_dir)))
            pend_dir_d = req_dir;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_dir_q <= DIR_RIGHT;
        else     pend_dir_q <= pend_dir_d;
    end

    assign pend_dir_o = pend_dir_q;

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake movement/body controller: steps the head one cell per move_en tick,
// shifts the segment store, handles growth and wall/self collision.
module snake_body_ctrl
    import snake_pkg::*;
#(
    parameter int GRID_W  = GRID_W_DEF,
    parameter int GRID_H  = GRID_H_DEF,
    parameter int XW      = XW_DEF,
    parameter int YW      = YW_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int START_X = START_X_DEF,
    parameter int START_Y = START_Y_DEF
) (
    input  logic         lcd_pclk,
    input  logic         rst,
    snake_body_ctrl_if.slave bus
);

    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam logic [XW:0] X_ONE = (XW+1)'(1);
    localparam logic [YW:0] Y_ONE = (YW+1)'(1);
    localparam logic [XW:0] X_LIM = (XW+1)'(GRID_W);
    localparam logic [YW:0] Y_LIM = (YW+1)'(GRID_H);

    state_e        state_q, state_d;
    dir_e          dir_q, dir_d, pend_dir;
    logic          grow_pend_q, grow_pend_d;
    logic [LW-1:0] len_q, len_d;
    logic          step_done_q, step_done_d;
    logic [XW-1:0] seg_x_q [MAX_LEN];
    logic [XW-1:0] seg_x_d [MAX_LEN];
    logic [YW-1:0] seg_y_q [MAX_LEN];
    logic [YW-1:0] seg_y_d [MAX_LEN];

    logic [XW:0]   nx;
    logic [YW:0]   ny;
    logic          wall_hit, self_hit, run_st, step_go;
    int            hit_lim;

    assign run_st  = (state_q == RUN);
    assign step_go = run_st && bus.move_en && !bus.start;

    snake_dir_filter u_dir_filter (
        .clk        (lcd_pclk),
        .rst        (rst),
        .init_i     (bus.start),
        .run_i      (run_st),
        .step_i     (step_go),
        .key_dir_i  (bus.key_dir),
        .dir_i      (dir_q),
        .pend_dir_o (pend_dir)
    );

    // One extra bit keeps a step off the 0 edge from wrapping into the grid.
    always_comb begin
        nx = {1'b0, seg_x_q[0]};
        ny = {1'b0, seg_y_q[0]};
        case (pend_dir)
            DIR_UP:    ny = ny - Y_ONE;
            DIR_RIGHT: nx = nx + X_ONE;
            DIR_DOWN:  ny = ny + Y_ONE;
            default:   nx = nx - X_ONE;
        endcase
        wall_hit = (nx >= X_LIM) || (ny >= Y_LIM);
    end

    // The tail cell is free to enter unless it stays put because we grow.
    always_comb begin
        self_hit = 1'b0;
        hit_lim  = grow_pend_q ? int'(len_q) - 1 : int'(len_q) - 2;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((i <= hit_lim) && (seg_x_q[i] == nx[XW-1:0]) &&
                (seg_y_q[i] == ny[YW-1:0]))
                self_hit = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        grow_pend_d = grow_pend_q;
        len_d       = len_q;
        step_done_d = 1'b0;
        seg_x_d     = seg_x_q;
        seg_y_d     = seg_y_q;
        if (bus.start) begin
            state_d     = RUN;
            dir_d       = DIR_RIGHT;
            grow_pend_d = 1'b0;
            len_d       = LW'(3);
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_d[i] = (i < 3) ? XW'(START_X - i) : '0;
                seg_y_d[i] = (i < 3) ? YW'(START_Y) : '0;
            end
        end else if (step_go) begin
            dir_d = pend_dir;
            if (wall_hit || self_hit) begin
                state_d = OVER;
            end else begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0] = nx[XW-1:0];
                seg_y_d[0] = ny[YW-1:0];
                if (grow_pend_q && (len_q < LW'(MAX_LEN)))
                    len_d = len_q + LW'(1);
                grow_pend_d = bus.grow;
                step_done_d = 1'b1;
            end
        end else if (run_st && bus.grow) begin
            grow_pend_d = 1'b1;
        end
    end

    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dir_q       <= DIR_RIGHT;
            grow_pend_q <= 1'b0;
            len_q       <= LW'(3);
            step_done_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < 3) ? XW'(START_X - i) : '0;
                seg_y_q[i] <= (i < 3) ? YW'(START_Y) : '0;
            end
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            grow_pend_q <= grow_pend_d;
            len_q       <= len_d;
            step_done_q <= step_done_d;
            seg_x_q     <= seg_x_d;
            seg_y_q     <= seg_y_d;
        end
    end

    assign bus.head_x    = seg_x_q[0];
    assign bus.head_y    = seg_y_q[0];
    assign bus.rd_x      = seg_x_q[bus.rd_idx];
    assign bus.rd_y      = seg_y_q[bus.rd_idx];
    assign bus.rd_valid  = (LW'(bus.rd_idx) < len_q);
    assign bus.snake_len = len_q;
    assign bus.running   = (state_q == RUN);
    assign bus.game_over = (state_q == OVER);
    assign bus.step_done = step_done_q;

endmodule
